// File: rtl/pps_pkg.sv
// Purpose: shared types and default constants for the PPS disciplining block and its RTC-side benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pps_pkg;

    // Discipline FSM encodings; the numeric values are visible to software/debug taps.
    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        LOCKED   = 2'd1,
        HOLDOVER = 2'd2
    } pps_state_t;

    // Nominal system clock rate and acceptance window for a real one-second interval.
    localparam int PPS_CLK_HZ       = 10_000_000;
    localparam int PPS_TOL_CYCLES   = 1_000;
    localparam int PPS_LOCK_COUNT   = 3;
    localparam int PPS_HOLDOVER_MAX = 3600;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Purpose: 3-flop synchroniser for the asynchronous PPS input plus rising-edge detect.
// Latency: rise is high during the 2nd clk after pps_in is first sampled high.
// Backpressure: none; rise is a one-cycle strobe.
// Ports: clk, rst (async, active-high), pps_in (raw async PPS), rise (one-cycle edge strobe).
// The chain presets to all ones so an input already high at reset release is not an edge.
module pps_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pps_in,
    output logic rise
);

    logic [2:0] sync;   // [0]=s1, [1]=s2, [2]=s3

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], pps_in};
        end
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/pps_discipline.sv
// Purpose: turns raw GPS PPS into a validated one-cycle pps strobe, with lock tracking and optional holdover.
// Latency: pps is high 3 clk after pps_in rises (2 sync flops + registered strobe).
// Backpressure: none; consumers must take pps the cycle it is high.
// Ports: clk, rst (async, active-high), pps_in (raw PPS), pps (second strobe), locked, holdover,
//        period (last accepted interval, clk cycles), holdover_sec (synthetic pulses this/last holdover).
// Build option: define PPS_HOLDOVER_EN to free-run from the last period when GPS pulses stop;
//        without it a lost lock returns to SEARCH and holdover/holdover_sec read 0.
module pps_discipline
    import pps_pkg::*;
#(
    parameter int CLK_HZ       = PPS_CLK_HZ,
    parameter int TOL_CYCLES   = PPS_TOL_CYCLES,
    parameter int LOCK_COUNT   = PPS_LOCK_COUNT,
    parameter int HOLDOVER_MAX = PPS_HOLDOVER_MAX,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pps_in,
    output logic             pps,
    output logic             locked,
    output logic             holdover,
    output logic [CNT_W-1:0] period,
    output logic [15:0]      holdover_sec
);

    localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(CLK_HZ - TOL_CYCLES);
    localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(CLK_HZ + TOL_CYCLES);
    // First interval length that can no longer be a valid second: lock is lost here.
    localparam logic [CNT_W-1:0]  LOSS_AT   = CNT_W'(CLK_HZ + TOL_CYCLES + 1);

    if (LOCK_COUNT < 1 || HOLDOVER_MAX < 1) begin : g_param_check
        $error("pps_discipline: LOCK_COUNT and HOLDOVER_MAX must be >= 1");
    end

    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  interval;
    logic              valid;
    logic [GOOD_W-1:0] good_cnt;
    pps_state_t        state;

    pps_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pps_in (pps_in),
        .rise   (rise)
    );

    // Interval length if a second boundary lands on this cycle.
    assign interval = cnt + CNT_W'(1);
    assign cnt_inc  = (cnt == '1) ? cnt : interval;
    assign valid    = (interval >= WIN_LO) && (interval <= WIN_HI);
    assign locked   = (state == LOCKED);

`ifdef PPS_HOLDOVER_EN
    localparam logic [CNT_W-1:0] HALF_SEC = CNT_W'(CLK_HZ / 2);

    logic [15:0] hsec;
    logic [15:0] hsec_inc;

    assign hsec_inc     = sat_inc16(hsec);
    assign holdover     = (state == HOLDOVER);
    assign holdover_sec = hsec;
`else
    assign holdover     = 1'b0;
    assign holdover_sec = 16'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            cnt      <= '0;
            good_cnt <= '0;
            pps      <= 1'b0;
            period   <= '0;
`ifdef PPS_HOLDOVER_EN
            hsec     <= 16'd0;
`endif
        end else begin
            pps <= 1'b0;
            cnt <= cnt_inc;
            case (state)
                SEARCH: begin
                    // Every edge is passed through while searching; only in-window ones build lock.
                    if (rise) begin
                        pps <= 1'b1;
                        cnt <= '0;
                        if (valid) begin
                            if (good_cnt == GOOD_LAST) begin
                                state    <= LOCKED;
                                period   <= interval;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    // An early edge is treated as a glitch: no strobe, and the running
                    // interval keeps counting toward the real boundary.
                    if (rise && valid) begin
                        pps    <= 1'b1;
                        period <= interval;
                        cnt    <= '0;
                    end else if (interval == LOSS_AT) begin
`ifdef PPS_HOLDOVER_EN
                        pps   <= 1'b1;
                        cnt   <= '0;
                        hsec  <= 16'd1;
                        state <= (HOLDOVER_MAX == 1) ? SEARCH : HOLDOVER;
`else
                        state    <= SEARCH;
                        good_cnt <= '0;
`endif
                    end
                end
`ifdef PPS_HOLDOVER_EN
                HOLDOVER: begin
                    // A returning real edge takes priority over a synthetic tick due the
                    // same cycle; it only strobes if the previous tick is far enough back.
                    if (rise) begin
                        state    <= SEARCH;
                        cnt      <= '0;
                        good_cnt <= '0;
                        if (interval >= HALF_SEC) begin
                            pps <= 1'b1;
                        end
                    end else if (interval == period) begin
                        pps  <= 1'b1;
                        cnt  <= '0;
                        hsec <= hsec_inc;
                        if (hsec_inc == 16'(HOLDOVER_MAX)) begin
                            state <= SEARCH;
                        end
                    end
                end
`endif
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pps_discipline.sv
// Purpose: self-checking bench for pps_discipline against an event-level model of the discipline rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_pps_discipline;

    localparam int CLK_HZ = 1000;
    localparam int TOL    = 10;
    localparam int LOCK   = 3;
    localparam int HMAX   = 4;
    localparam int LO     = CLK_HZ - TOL;
    localparam int HI     = CLK_HZ + TOL;
    localparam int MAXC   = 10600;
    localparam int INF    = 32'h7fff_ffff;
    localparam int PULSE  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pps_in = 1'b0;
    logic        pps;
    logic        locked;
    logic        holdover;
    logic [31:0] period;
    logic [15:0] holdover_sec;

    int vectors = 0;
    int miscompares = 0;

    // Stimulus: cycles after which pps_in is driven high for PULSE cycles.
    int drives[$];
    int init_hi = 0;
    int ncyc = 0;
    int cyc = 0;
    bit checking = 1'b0;
    int scen = 0;

    // Expected outputs after each posedge, indexed by posedge number since reset release.
    bit e_pps [0:MAXC];
    int e_st  [0:MAXC];
    int e_per [0:MAXC];
    int e_hs  [0:MAXC];

    always #5 clk = ~clk;

    pps_discipline #(
        .CLK_HZ       (CLK_HZ),
        .TOL_CYCLES   (TOL),
        .LOCK_COUNT   (LOCK),
        .HOLDOVER_MAX (HMAX),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pps_in       (pps_in),
        .pps          (pps),
        .locked       (locked),
        .holdover     (holdover),
        .period       (period),
        .holdover_sec (holdover_sec)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic put(input int t, input bit p, input int st, input int per, input int hs);
        e_pps[t] = p;
        e_st[t]  = st;
        e_per[t] = per;
        e_hs[t]  = hs;
    endtask

    // Event-level model: walks second boundaries (accepted real edges, loss timeouts,
    // synthetic ticks) in time order. Interval = boundary time - last counter clear,
    // where reset counts as a clear at time 0. Real edges land 3 cycles after the drive.
    task automatic build_model(input int n);
        int acc[$];
        int st, lc, good, per, hs, idx, cur, ta, tt, te, iv;
        bit p, rise, done;
        foreach (drives[i]) acc.push_back(drives[i] + 3);
        st = 0; lc = 0; good = 0; per = 0; hs = 0; idx = 0; cur = 1; done = 1'b0;
        put(0, 1'b0, 0, 0, 0);
        while (!done) begin
            ta = (idx < acc.size()) ? acc[idx] : INF;
            tt = (st == 1) ? lc + HI + 1 : (st == 2) ? lc + per : INF;
            te = (ta < tt) ? ta : tt;
            if (te > n) begin
                done = 1'b1;
            end else begin
                for (int t = cur; t < te; t++) put(t, 1'b0, st, per, hs);
                rise = (ta == te);
                iv = te - lc;
                p = 1'b0;
                if (st == 0) begin
                    p = 1'b1;
                    lc = te;
                    if (iv >= LO && iv <= HI) begin
                        good++;
                        if (good == LOCK) begin st = 1; per = iv; good = 0; end
                    end else begin
                        good = 0;
                    end
                end else if (st == 1) begin
                    if (rise && iv >= LO && iv <= HI) begin
                        p = 1'b1; per = iv; lc = te;
                    end else if (te == lc + HI + 1) begin
`ifdef PPS_HOLDOVER_EN
                        p = 1'b1; lc = te; hs = 1; st = (HMAX == 1) ? 0 : 2;
`else
                        st = 0; good = 0;
`endif
                    end
                end else begin
                    if (rise) begin
                        st = 0; lc = te; good = 0;
                        p = (iv >= CLK_HZ / 2);
                    end else begin
                        p = 1'b1; lc = te;
                        hs = (hs == 65535) ? hs : hs + 1;
                        if (hs == HMAX) st = 0;
                    end
                end
                if (rise) idx++;
                put(te, p, st, per, hs);
                cur = te + 1;
            end
        end
        for (int t = cur; t <= n; t++) put(t, 1'b0, st, per, hs);
    endtask

    function automatic logic drive_level(input int t);
        logic lvl;
        lvl = (t < init_hi);
        foreach (drives[i]) if (t >= drives[i] && t < drives[i] + PULSE) lvl = 1'b1;
        return lvl;
    endfunction

    // Single compare process: every cycle of a scenario against the model.
    always @(negedge clk) begin
        if (checking && cyc >= 1 && cyc <= ncyc) begin
            vectors++;
            if (pps !== e_pps[cyc] || locked !== (e_st[cyc] == 1) || holdover !== (e_st[cyc] == 2)
                || period !== 32'(e_per[cyc]) || holdover_sec !== 16'(e_hs[cyc])) begin
                miscompares++;
                if (miscompares <= 30)
                    $display("FAIL scen%0d cycle %0d pps/locked/holdover/period/hsec: got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                             scen, cyc, pps, locked, holdover, period, holdover_sec,
                             e_pps[cyc], e_st[cyc] == 1, e_st[cyc] == 2, e_per[cyc], e_hs[cyc]);
            end
        end
    end

    // Assert reset between clock edges; outputs must clear immediately.
    task automatic do_reset(input logic hold_hi);
        @(posedge clk);
        #2;
        pps_in = hold_hi;
        rst = 1'b1;
        #1;
        check("reset_pps", {63'd0, pps}, 64'd0);
        check("reset_locked", {63'd0, locked}, 64'd0);
        check("reset_holdover", {63'd0, holdover}, 64'd0);
        check("reset_period", {32'd0, period}, 64'd0);
        check("reset_hsec", {48'd0, holdover_sec}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_scen(input int id, input int n);
        scen = id;
        ncyc = n;
        build_model(n);
        checking = 1'b1;
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            #1;
            cyc = t;
            pps_in = drive_level(t);
        end
        @(negedge clk);
        #1;
        checking = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // 1: lock, boundary intervals 990/1010, glitch at 300, sub-window 989 glitch then loss.
        do_reset(1'b0);
        drives = '{50, 1050, 2050, 3050, 4040, 5050, 5350, 6050, 7039};
        init_hi = 0;
        build_model(10500);
        check("model_first_edge_pps", 64'(e_pps[1053]), 64'd1);
        check("model_search_before_lock", 64'(e_st[3052]), 64'd0);
        check("model_locked_4th_edge", 64'(e_st[3053]), 64'd1);
        check("model_period_lock", 64'(e_per[3053]), 64'd1000);
        check("model_period_990", 64'(e_per[4043]), 64'd990);
        check("model_period_1010", 64'(e_per[5053]), 64'd1010);
        check("model_glitch_no_pps", 64'(e_pps[5353]), 64'd0);
        check("model_after_glitch_pps", 64'(e_pps[6053]), 64'd1);
`ifdef PPS_HOLDOVER_EN
        check("model_loss_pps_1011", 64'(e_pps[7064]), 64'd1);
        check("model_synth_1000", 64'(e_pps[8064]), 64'd1);
        check("model_hsec_max", 64'(e_hs[10064]), 64'd4);
        check("model_hmax_search", 64'(e_st[10064]), 64'd0);
`else
        check("model_loss_no_pps", 64'(e_pps[7064]), 64'd0);
        check("model_loss_search", 64'(e_st[7064]), 64'd0);
`endif
        run_scen(1, 10500);

        // 2: real edge 200 clk after a synthetic tick.
        do_reset(1'b0);
        drives = '{50, 1050, 2050, 3050, 5261};
        build_model(5400);
`ifdef PPS_HOLDOVER_EN
        check("model_late_edge_no_pps", 64'(e_pps[5264]), 64'd0);
`else
        check("model_late_edge_pps", 64'(e_pps[5264]), 64'd1);
`endif
        check("model_late_edge_search", 64'(e_st[5264]), 64'd0);
        run_scen(2, 5400);

        // 3: real edge on the same cycle a synthetic tick is due.
        do_reset(1'b0);
        drives = '{50, 1050, 2050, 3050, 5061};
        build_model(5300);
        check("model_coincident_one_pps", 64'(e_pps[5064]), 64'd1);
        run_scen(3, 5300);

        // 4: reset asserted mid-holdover with pps_in high across release.
        do_reset(1'b0);
        drives = '{50, 1050, 2050, 3050};
        run_scen(4, 4500);
        do_reset(1'b1);
        drives = '{};
        init_hi = 30;
        run_scen(5, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
